// File: rtl/dlfloat_dot_acc_if.sv
// Operand and result stream bundle for dlfloat_dot_acc.
// The slave side is the dot-product engine, the master side is its driver.
interface dlfloat_dot_acc_if #(
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/dlfloat_dot_acc.sv
// Streaming DLFloat16 dot-product: multiply each operand pair, accumulate one sum per vector.
// Define DLF_ROUND_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module dlfloat_dot_acc #(
  parameter int VEC_LEN = 16,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  dlfloat_dot_acc_if.slave bus
);

`ifdef DLF_ROUND_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Returns {ovf, value}; underflow is judged on the pre-rounding exponent.
  function automatic logic [16:0] round_sat(input logic s, input logic signed [8:0] e,
                                            input logic [8:0] m, input logic g, input logic rs);
    logic [9:0]        mr;
    logic signed [8:0] er;
    if (e < 9'sd1) return 17'd0;
    mr = {1'b0, m} + {9'd0, RNE & g & (rs | m[0])};
    er = mr[9] ? e + 9'sd1 : e;
    if (er > 9'sd63) return {1'b1, s, 15'h7FFF};
    return {1'b0, s, er[5:0], mr[8:0]};
  endfunction

  function automatic logic [16:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [19:0]       pr;
    logic signed [8:0] e;
    logic [8:0]        m;
    logic              g;
    logic              rs;
    if (a[14:9] == 6'd0 || b[14:9] == 6'd0) return 17'd0;
    pr = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
    e  = $signed({3'b000, a[14:9]}) + $signed({3'b000, b[14:9]}) - 9'sd31
       + $signed({8'd0, pr[19]});
    if (pr[19]) begin
      m = pr[18:10]; g = pr[9]; rs = |pr[8:0];
    end else begin
      m = pr[17:9];  g = pr[8]; rs = |pr[7:0];
    end
    return round_sat(a[15] ^ b[15], e, m, g, rs);
  endfunction

  // Aligned operand keeps guard, round and a jammed sticky bit below the mantissa.
  function automatic logic [16:0] fp_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       big;
    logic [15:0]       sml;
    logic [5:0]        d;
    logic [25:0]       sh;
    logic [12:0]       ab;
    logic [12:0]       al;
    logic [13:0]       s14;
    logic [13:0]       n14;
    logic [3:0]        p;
    logic signed [8:0] e;
    if (x[14:9] == 6'd0) return {1'b0, y};
    if (y[14:9] == 6'd0) return {1'b0, x};
    if (x[14:0] >= y[14:0]) begin
      big = x; sml = y;
    end else begin
      big = y; sml = x;
    end
    d   = big[14:9] - sml[14:9];
    ab  = {1'b1, big[8:0], 3'b000};
    sh  = {1'b1, sml[8:0], 16'd0} >> d;
    al  = (d > 6'd13) ? 13'd1 : {sh[25:14], sh[13] | (|sh[12:0])};
    s14 = (big[15] ^ sml[15]) ? ({1'b0, ab} - {1'b0, al}) : ({1'b0, ab} + {1'b0, al});
    p   = 4'd0;
    for (int i = 0; i < 14; i++) if (s14[i]) p = 4'(i);
    n14 = s14 << (4'd13 - p);
    if (!n14[13]) return 17'd0;
    e = $signed({3'b000, big[14:9]}) + $signed({5'b00000, p}) - 9'sd12;
    return round_sat(big[15], e, n14[12:4], n14[3], |n14[2:0]);
  endfunction

  logic [1:0]       state;
  logic             run_en;
  logic             vld_p1;
  logic             povf_p1;
  logic [15:0]      prod_p1;
  logic [15:0]      acc_p2;
  logic             ovf_p2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             close_vec;
  logic [16:0]      mul_r;
  logic [16:0]      add_r;

  assign bus.in_ready  = run_en && (state == IDLE || state == RUN);
  assign accept        = bus.in_valid && bus.in_ready;
  assign cnt_nxt       = cnt + CNT_W'(1);
  assign mul_r         = fp_mul(bus.in_a, bus.in_b);
  assign add_r         = fp_add(acc_p2, prod_p1);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = acc_p2;
  assign bus.out_count = cnt;
  assign bus.out_ovf   = ovf_p2;

  always_comb begin
    close_vec = 1'b0;
    if (state == IDLE) close_vec = bus.in_last || (VEC_LEN == 1);
    else               close_vec = bus.in_last || (cnt_nxt == CNT_W'(VEC_LEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_en  <= 1'b0;
      vld_p1  <= 1'b0;
      povf_p1 <= 1'b0;
      prod_p1 <= 16'd0;
      acc_p2  <= 16'd0;
      ovf_p2  <= 1'b0;
      cnt     <= '0;
    end else begin
      run_en <= 1'b1;
      // S1: product register
      vld_p1 <= accept;
      if (accept) begin
        prod_p1 <= mul_r[15:0];
        povf_p1 <= mul_r[16];
      end
      // S2: accumulator, cleared by the first beat of a vector
      if (accept && state == IDLE) begin
        acc_p2 <= 16'd0;
        ovf_p2 <= 1'b0;
      end else if (vld_p1) begin
        acc_p2 <= add_r[15:0];
        ovf_p2 <= ovf_p2 | povf_p1 | add_r[16];
      end
      if (accept) cnt <= (state == IDLE) ? CNT_W'(1) : cnt_nxt;
      case (state)
        IDLE, RUN: if (accept) state <= close_vec ? FLUSH : RUN;
        FLUSH:     state <= HOLD;
        HOLD:      if (bus.out_ready) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dlfloat_dot_acc.md
Name: dlfloat_dot_acc

Overview:
- Streaming DLFloat16 dot-product engine: accepts operand pairs (a,b) over a valid/ready stream, multiplies each pair, and accumulates the products into one DLFloat16 sum per vector.
- A vector ends on in_last or after VEC_LEN beats. The block then presents the sum, beat count and overflow flag on a valid/ready output.
- Successor to the fixed two-register MAC. Sits between the pin-level operand loader and the result mux.

Parameters:
VEC_LEN, 16, maximum beats per vector (>=1); the vector closes automatically when this count is reached
CNT_W, $clog2(VEC_LEN+1), width of the beat counter and out_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts pair this cycle
in_a  in  16  DLFloat16 operand a
in_b  in  16  DLFloat16 operand b
in_last  in  1  final pair of the vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  16  accumulated DLFloat16 sum
out_count  out  CNT_W  beats accumulated in this vector
out_ovf  out  1  sticky: saturation occurred in this vector

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. Asserting it clears the FSM to IDLE, product register, accumulator, counter and ovf. Outputs go to in_ready=0, out_valid=0, out_data=0, out_count=0, out_ovf=0. in_ready=1 from the first cycle after release. Reset mid-vector discards all partial state.
- Format: {s[15], e[14:9], m[8:0]}, bias 31, value (-1)^s * 1.m * 2^(e-31).
  - e=0 is zero, whatever m is. No subnormals.
  - e=1..63 is finite. Max magnitude is 0x7FFF. No Inf/NaN.
- Multiply:
  - If either operand is zero, the product is 0x0000.
  - Otherwise e=ea+eb-31, with +1 when the 10x10 mantissa product is >=2.0.
  - Normalized e<1 flushes to 0x0000 and does not set ovf.
  - e>63 saturates to {s,0x3F,0x1FF} and sets ovf.
- Add (acc + product):
  - Align the smaller exponent using 3 guard bits. Add or subtract by sign. Renormalize with a leading-one search covering the full width.
  - Result sign is the sign of the larger magnitude. Exact cancellation gives +0 (0x0000).
  - Exponent >63 saturates and sets ovf. Exponent <1 flushes to zero.
- Pipeline: S1 registers the product; S2 updates the accumulator. Initiation interval is 1 beat per cycle.
- FSM states:
  - IDLE: in_ready=1. The first accepted beat clears the accumulator to 0, loads S1 and sets count=1. Go to FLUSH if in_last or VEC_LEN==1, else RUN.
  - RUN: in_ready=1. Each accepted beat increments count and feeds the pipeline; cycles with in_valid=0 are bubbles. A beat with in_last, or with count reaching VEC_LEN, goes to FLUSH.
  - FLUSH: in_ready=0. One cycle while the final product enters the accumulator, then go to HOLD.
  - HOLD: out_valid=1; out_data, out_count and out_ovf are stable while out_ready=0, and in_ready=0. On out_valid&&out_ready go to IDLE.
- Latency: final beat accepted at edge k; out_valid is high from the cycle after edge k+1.
- in_last is ignored while in_valid=0.
- Accepting a beat and completing the output handshake in the same cycle cannot happen, since in_ready=0 in FLUSH and HOLD.
- out_count never exceeds VEC_LEN. The counter is cleared when each new vector starts.

Optional Feature:
DLF_ROUND_RNE_EN
- Defined: multiplier and adder round to nearest, ties to even, using the guard, round and sticky bits. A rounding carry that reaches e>63 saturates and sets ovf.
- Undefined: both truncate toward zero; the guard bits are discarded.
- All other behaviour is unchanged in both builds.

Test Plan:
- 2 beats: (0x3E00,0x3E00), then (0x4000,0x3F00) with in_last -> out_data=0x4200 (4.0), out_count=2, out_ovf=0.
- VEC_LEN=16, 16 beats of (0x3E00,0x3E00), no in_last -> after the 16th accept in_ready=0; out_data=0x4600 (16.0), out_count=16.
- Cancellation: (0x3E00,0x3F00), then (0xBE00,0x3F00) with last -> out_data=0x0000, out_ovf=0.
- Overflow: (0x7E00,0x4000) with last -> out_data=0x7FFF, out_ovf=1. The next vector (0x3E00,0x3E00) with last -> out_data=0x3E00, out_ovf=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. After the handshake, IDLE follows and in_ready=1.
- Reset mid-RUN after 3 beats -> all outputs zero. A fresh 1-beat vector (0x4000,0x4000) with last -> out_data=0x4200, out_count=1.
